// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin sharing of one pipelined adder among NUM_REQ
//               requesters, with one-hot tagged responses and run/drain FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int RES_W     = 7,
    parameter int ADDER_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [DATA_W-1:0]         adder_a,
    output logic [DATA_W-1:0]         adder_b,
    output logic                      adder_valid,
    input  logic [RES_W-1:0]          adder_c,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_c,
    output logic                      idle
);

    localparam int                 c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W:0]   c_NUM_REQ = (c_PTR_W+1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(NUM_REQ-1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_issue_en;
    logic               w_idle;
    logic               w_busy;

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;

    logic [DATA_W-1:0]  w_a [NUM_REQ];
    logic [DATA_W-1:0]  w_b [NUM_REQ];

    logic [DATA_W-1:0]  r_adder_a;
    logic [DATA_W-1:0]  r_adder_b;
    logic               r_adder_valid;
    logic [NUM_REQ-1:0] r_tag [ADDER_LAT+1];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [RES_W-1:0]   r_rsp_c;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a[gi*DATA_W +: DATA_W];
            assign w_b[gi] = req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (arb_en) w_state_nxt = c_RUN;
            c_RUN:   if (!arb_en) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (arb_en)       w_state_nxt = c_RUN;
                else if (!w_busy) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs; arb_en gates issue in the same cycle it falls
    always_comb begin
        w_issue_en = (r_state == c_RUN) && arb_en;
        w_idle     = (r_state == c_IDLE) && !w_busy;
    end

    // Round-robin search starting at r_rr_ptr, wrapping past NUM_REQ-1
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (w_issue_en && !w_found && req_valid[w_sum[c_PTR_W-1:0]]) begin
                w_found                       = 1'b1;
                w_grant_idx                   = w_sum[c_PTR_W-1:0];
                w_grant[w_sum[c_PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_adder_a     <= '0;
            r_adder_b     <= '0;
            r_adder_valid <= 1'b0;
        end else begin
            r_adder_valid <= w_found;
            if (w_found) begin
                r_adder_a <= w_a[w_grant_idx];
                r_adder_b <= w_b[w_grant_idx];
                r_rr_ptr  <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + c_PTR_W'(1);
            end
        end
    end

    // Grant tags travel alongside the adder so each result knows its owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s <= ADDER_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_grant;
            for (int s = 1; s <= ADDER_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s <= ADDER_LAT; s++) begin
            w_busy = w_busy | (|r_tag[s]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_c     <= '0;
        end else begin
            r_rsp_valid <= r_tag[ADDER_LAT];
            if (|r_tag[ADDER_LAT]) begin
                r_rsp_c <= adder_c;
            end
        end
    end

    assign req_ready   = w_grant;
    assign adder_a     = r_adder_a;
    assign adder_b     = r_adder_b;
    assign adder_valid = r_adder_valid;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_c       = r_rsp_c;
    assign idle        = w_idle;

endmodule
`default_nettype wire
